mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline, sitting between execution and writeback.
- Consumes the execution-stage ALU result, store data, destination register, PC and imm32, and resolves jump/branch targets.
- Performs byte/half/word loads and stores over a variable-latency data-memory req/ack handshake, stalling upstream while an access is outstanding.
- Its registered result drives writeback and the Mem-stage forwarding path back into execution.

Parameters:
- ACK_TIMEOUT, 255: max cycles dmem_req is held without dmem_ack before a bus error is declared.
- TMO_W, 8: width of the timeout counter; must satisfy ACK_TIMEOUT < 2^TMO_W.

Ports:
- clk  in  1  stage clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  execution-stage output holds a valid instruction.
- ALU_result  in  32  effective address for load/store; link value for jal/jalr; bit0 is the branch-taken result.
- Rdata1  in  32  rs1 value, used for the jalr target.
- Rdata2  in  32  store data.
- imm32  in  32  immediate.
- PC  in  32  instruction PC.
- Rd_Exec  in  5  destination register.
- reg_wEn_Exec  in  1  instruction writes Rd.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_size  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word.
- mem_unsigned  in  1  zero-extend the load.
- jump_kind  in  2  00 none, 01 branch, 10 jal, 11 jalr.
- stall  out  1  hold execution and earlier stages.
- jump_flag  out  1  redirect the fetch PC.
- jump_target_PC  out  32  redirect target.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  request completes this cycle.
- dmem_rdata  in  32  read word, valid when dmem_ack=1.
- wb_valid  out  1  W register holds a completed instruction.
- Rd_Mem  out  5  destination register.
- wrEn_Mem  out  1  write register file.
- Data_mem_Mem  out  32  writeback / forwarding data.
- misalign_exc  out  1  pulse, one cycle, with the offending result.
- bus_err  out  1  pulse, one cycle, on ack timeout.

Behaviour:
- Two register sets:
  - S: instruction in MEM.
  - W: completed result driving the writeback-side outputs.
- Reset (asynchronous):
  - S and W cleared; state=IDLE; counter=0.
  - All outputs are 0, combinational ones included: dmem_req drops immediately.
  - An ack arriving after reset deasserts is ignored.
- Accept: when stall=0, S <= inputs and S.valid <= in_valid.
- Memory operation: S.valid & (mem_read | mem_write).
  - Aligned if byte; half with addr[0]=0; word with addr[1:0]=0.
- Request:
  - dmem_req = S.valid & memop & aligned & state==IDLE, combinational from S.
  - dmem_addr = {addr[31:2],00}.
- Store lanes:
  - Byte: be = 0001 << addr[1:0]; wdata = Rdata2[7:0] replicated x4.
  - Half: be = 0011 << addr[1:0]; wdata = Rdata2[15:0] replicated x2.
  - Word: be = 1111.
  - Loads drive be = 1111.
- Stall: stall = dmem_req & ~dmem_ack. A zero-wait ack (same cycle as req) produces no stall.
- FSM:
  - States are IDLE and ERR_DRAIN (one cycle).
  - While dmem_req & ~dmem_ack, counter increments.
  - On counter == ACK_TIMEOUT-1 without ack, W is written with bus_err=1 and wrEn=0, and the next state is ERR_DRAIN.
  - In ERR_DRAIN, dmem_req is forced to 0 and stall=0 so S can advance.
  - The counter clears on ack or timeout.
- W update on every edge where stall=0 and S.valid:
  - Load, on ack: W.data = formatted dmem_rdata. The lane is selected by addr[1:0]; sign-extend unless mem_unsigned. W.wrEn = reg_wEn.
  - Store: W.wrEn = 0.
  - Misaligned: no request is issued; W.wrEn = 0; misalign_exc = 1.
  - Non-memory: W.data = ALU_result; W.wrEn = reg_wEn.
  - wrEn_Mem is forced 0 when Rd=0.
- W update when stall=0 and ~S.valid: wb_valid <= 0 and wrEn <= 0.
- Jump resolution (combinational from S):
  - branch: taken if ALU_result[0]=1.
  - jal: target = PC+imm32, always taken.
  - jalr: target = (Rdata1+imm32) & ~1, always taken.
  - jump_flag = S.valid & taken, held while stalled.
- Latency:
  - Non-memory: 1 cycle in S, visible in W on the following edge.
  - Load/store: W is written on the ack edge.
  - Back-to-back accepts every cycle when there are zero-wait acks.

Decomposition:
- mem_stage_pkg holds:
  - Localparams for the mem_size and jump_kind encodings.
  - Functions for be/wdata lane generation.
  - The ACK_TIMEOUT default.
- One sub-module, load_align: combinational; rdata, addr[1:0], size, unsigned -> 32-bit extended data.

Test Plan:
- lb at addr 0x103, mem_unsigned=0, dmem_rdata 0x80FF_0000, ack after 3 cycles -> stall high for 3 cycles; then Data_mem_Mem=0xFFFF_FF80, wrEn_Mem=1.
- sh Rdata2=0x1234ABCD at 0x202, zero-wait ack -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, stall never high, wrEn_Mem=0.
- lw at 0x106 -> no dmem_req, misalign_exc pulse, wrEn_Mem=0.
- jalr Rdata1=0x1001, imm32=4, ALU_result=PC+4 -> jump_flag=1, jump_target_PC=0x1004, Data_mem_Mem=PC+4.
- Load with no ack, ACK_TIMEOUT=8 -> stall for 8 cycles, bus_err pulse, dmem_req 0 in ERR_DRAIN, next instruction accepted.
- rst asserted mid-wait -> dmem_req and stall 0 asynchronously; a late ack after release leaves W unchanged (wb_valid=0).

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - encodings, register types and store-lane helpers for mem_access
package mem_stage_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [1:0] JK_NONE   = 2'b00;
   localparam logic [1:0] JK_BRANCH = 2'b01;
   localparam logic [1:0] JK_JAL    = 2'b10;
   localparam logic [1:0] JK_JALR   = 2'b11;

   localparam int ACK_TIMEOUT_DEF = 255;

   typedef enum logic {ST_IDLE, ST_ERR_DRAIN} state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] alu;
      logic [31:0] rdata1;
      logic [31:0] rdata2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        reg_wen;
      logic        mem_read;
      logic        mem_write;
      logic [1:0]  size;
      logic        is_unsigned;
      logic [1:0]  jump_kind;
   } s_reg_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic        wren;
      logic [31:0] data;
      logic        misalign;
      logic        bus_err;
   } w_reg_t;

   // Reserved size 2'b11 behaves as a word everywhere.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: is_aligned = 1'b1;
         SIZE_HALF: is_aligned = ~off[0];
         default:   is_aligned = (off == 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: lane_be = 4'b0001 << off;
         SIZE_HALF: lane_be = 4'b0011 << off;
         default:   lane_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SIZE_BYTE: lane_wdata = {4{data[7:0]}};
         SIZE_HALF: lane_wdata = {2{data[15:0]}};
         default:   lane_wdata = data;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half of a read word and extends it to 32 bits
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      case (off)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SIZE_BYTE: data = {{24{b[7] & ~is_unsigned}}, b};
         SIZE_HALF: data = {{16{h[15] & ~is_unsigned}}, h};
         default:   data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory-access stage with variable-latency data-memory handshake
module mem_access
   import mem_stage_pkg::*;
#(
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
   parameter int TMO_W       = 8
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] ALU_result,
   input  logic [31:0] Rdata1,
   input  logic [31:0] Rdata2,
   input  logic [31:0] imm32,
   input  logic [31:0] PC,
   input  logic [4:0]  Rd_Exec,
   input  logic        reg_wEn_Exec,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic [1:0]  jump_kind,
   output logic        stall,
   output logic        jump_flag,
   output logic [31:0] jump_target_PC,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [4:0]  Rd_Mem,
   output logic        wrEn_Mem,
   output logic [31:0] Data_mem_Mem,
   output logic        misalign_exc,
   output logic        bus_err
);

   s_reg_t           s_q, s_in;
   w_reg_t           w_q;
   state_t           state_q, state_d;
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             memop, aligned, wait_ack, timeout, taken;
   logic [31:0]      load_data;

   assign s_in = '{valid: in_valid, alu: ALU_result, rdata1: Rdata1, rdata2: Rdata2,
                   imm: imm32, pc: PC, rd: Rd_Exec, reg_wen: reg_wEn_Exec,
                   mem_read: mem_read, mem_write: mem_write, size: mem_size,
                   is_unsigned: mem_unsigned, jump_kind: jump_kind};

   assign memop    = s_q.valid & (s_q.mem_read | s_q.mem_write);
   assign aligned  = is_aligned(s_q.size, s_q.alu[1:0]);
   assign dmem_req = memop & aligned & (state_q == ST_IDLE);
   assign wait_ack = dmem_req & ~dmem_ack;
   assign stall    = wait_ack;
   assign timeout  = wait_ack & (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1));

   assign dmem_we    = dmem_req & s_q.mem_write;
   assign dmem_addr  = {s_q.alu[31:2], 2'b00};
   assign dmem_be    = !memop ? 4'b0000 :
                       s_q.mem_write ? lane_be(s_q.size, s_q.alu[1:0]) : 4'b1111;
   assign dmem_wdata = s_q.mem_write ? lane_wdata(s_q.size, s_q.rdata2) : 32'd0;

   load_align u_load_align (
      .rdata       (dmem_rdata),
      .off         (s_q.alu[1:0]),
      .size        (s_q.size),
      .is_unsigned (s_q.is_unsigned),
      .data        (load_data)
   );

   always_comb begin
      taken          = 1'b0;
      jump_target_PC = s_q.pc + s_q.imm;
      case (s_q.jump_kind)
         JK_BRANCH: taken = s_q.alu[0];
         JK_JAL:    taken = 1'b1;
         JK_JALR: begin
            taken          = 1'b1;
            jump_target_PC = (s_q.rdata1 + s_q.imm) & ~32'd1;
         end
         default: ;
      endcase
   end

   assign jump_flag = s_q.valid & taken;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (timeout) state_d = ST_ERR_DRAIN;
         ST_ERR_DRAIN: state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tmo_cnt_q <= '0;
         s_q       <= '0;
         w_q       <= '0;
      end else begin
         state_q <= state_d;

         if (wait_ack && !timeout)
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         else if (dmem_ack || timeout)
            tmo_cnt_q <= '0;

         if (!stall)
            s_q <= s_in;

         // Exception flags live for exactly one cycle, whatever happens to W.
         w_q.misalign <= 1'b0;
         w_q.bus_err  <= 1'b0;

         if (timeout) begin
            w_q.valid   <= 1'b1;
            w_q.rd      <= s_q.rd;
            w_q.wren    <= 1'b0;
            w_q.data    <= s_q.alu;
            w_q.bus_err <= 1'b1;
         end else if (state_q == ST_ERR_DRAIN) begin
            // The errored instruction already retired into W; let S advance past it.
            w_q.valid <= 1'b0;
            w_q.wren  <= 1'b0;
         end else if (!stall) begin
            if (!s_q.valid) begin
               w_q.valid <= 1'b0;
               w_q.wren  <= 1'b0;
            end else begin
               w_q.valid <= 1'b1;
               w_q.rd    <= s_q.rd;
               w_q.data  <= s_q.alu;
               if (memop && !aligned) begin
                  w_q.wren     <= 1'b0;
                  w_q.misalign <= 1'b1;
               end else if (s_q.mem_write) begin
                  w_q.wren <= 1'b0;
               end else if (s_q.mem_read) begin
                  w_q.data <= load_data;
                  w_q.wren <= s_q.reg_wen & (|s_q.rd);
               end else begin
                  w_q.wren <= s_q.reg_wen & (|s_q.rd);
               end
            end
         end
      end
   end

   assign wb_valid     = w_q.valid;
   assign Rd_Mem       = w_q.rd;
   assign wrEn_Mem     = w_q.wren;
   assign Data_mem_Mem = w_q.data;
   assign misalign_exc = w_q.misalign;
   assign bus_err      = w_q.bus_err;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed and randomized self-checking bench for mem_access
module tb_mem_access;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] ALU_result, Rdata1, Rdata2, imm32, PC;
   logic [4:0]  Rd_Exec;
   logic        reg_wEn_Exec, mem_read, mem_write, mem_unsigned;
   logic [1:0]  mem_size, jump_kind;
   logic        stall, jump_flag, dmem_req, dmem_we, dmem_ack;
   logic [31:0] jump_target_PC, dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_valid, wrEn_Mem, misalign_exc, bus_err;
   logic [4:0]  Rd_Mem;
   logic [31:0] Data_mem_Mem;

   always #5 clk = ~clk;

   mem_access #(.ACK_TIMEOUT(TMO), .TMO_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .ALU_result(ALU_result),
      .Rdata1(Rdata1), .Rdata2(Rdata2), .imm32(imm32), .PC(PC), .Rd_Exec(Rd_Exec),
      .reg_wEn_Exec(reg_wEn_Exec), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .jump_kind(jump_kind),
      .stall(stall), .jump_flag(jump_flag), .jump_target_PC(jump_target_PC),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .Rd_Mem(Rd_Mem),
      .wrEn_Mem(wrEn_Mem), .Data_mem_Mem(Data_mem_Mem),
      .misalign_exc(misalign_exc), .bus_err(bus_err)
   );

   typedef struct {
      logic [31:0] alu, r1, r2, imm, pc;
      logic [4:0]  rd;
      logic        wen, rd_op, wr_op, uns;
      logic [1:0]  size, jk;
   } instr_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic instr_t nop_instr();
      instr_t i;
      i = '{alu: 0, r1: 0, r2: 0, imm: 0, pc: 0, rd: 0, wen: 0, rd_op: 0, wr_op: 0,
            uns: 0, size: 0, jk: 0};
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      int kind;
      kind    = $urandom_range(0, 3);
      i       = nop_instr();
      i.alu   = $urandom;
      i.r1    = $urandom;
      i.r2    = $urandom;
      i.imm   = $urandom;
      i.pc    = $urandom;
      i.rd    = 5'($urandom);
      i.wen   = 1'($urandom);
      i.uns   = 1'($urandom);
      i.size  = 2'($urandom);
      i.rd_op = (kind == 1);
      i.wr_op = (kind == 2);
      i.jk    = (kind == 3) ? 2'($urandom_range(1, 3)) : 2'd0;
      return i;
   endfunction

   task automatic drive(input instr_t i, input logic v);
      in_valid = v; ALU_result = i.alu; Rdata1 = i.r1; Rdata2 = i.r2; imm32 = i.imm;
      PC = i.pc; Rd_Exec = i.rd; reg_wEn_Exec = i.wen; mem_read = i.rd_op;
      mem_write = i.wr_op; mem_size = i.size; mem_unsigned = i.uns; jump_kind = i.jk;
   endtask

   // Reference rules, written from the architectural description.
   function automatic bit m_memop(instr_t i);
      return i.rd_op || i.wr_op;
   endfunction

   function automatic bit m_aligned(instr_t i);
      int off;
      off = int'(i.alu % 4);
      if (i.size == 0) return 1;
      if (i.size == 1) return (off % 2) == 0;
      return off == 0;
   endfunction

   function automatic bit m_req(instr_t i);
      return m_memop(i) && m_aligned(i);
   endfunction

   function automatic logic [3:0] m_be(instr_t i);
      int v;
      if (!i.wr_op) return 4'hF;
      if (i.size == 0) v = 1 << (i.alu % 4);
      else if (i.size == 1) v = 3 << (i.alu % 4);
      else v = 15;
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(instr_t i);
      if (i.size == 0) return (i.r2 & 32'hFF) * 32'h0101_0101;
      if (i.size == 1) return (i.r2 & 32'hFFFF) * 32'h0001_0001;
      return i.r2;
   endfunction

   function automatic logic [31:0] m_load(instr_t i, logic [31:0] rdata);
      logic [31:0] v;
      v = rdata >> (8 * (i.alu % 4));
      if (i.size == 0) begin
         v = v & 32'hFF;
         if (!i.uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (i.size == 1) begin
         v = v & 32'hFFFF;
         if (!i.uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   function automatic bit m_wren(instr_t i);
      if (i.wr_op) return 0;
      if (m_memop(i) && !m_aligned(i)) return 0;
      return i.wen && (i.rd != 0);
   endfunction

   function automatic bit m_taken(instr_t i);
      if (i.jk == 1) return i.alu[0];
      return i.jk != 0;
   endfunction

   function automatic logic [31:0] m_target(instr_t i);
      if (i.jk == 3) return (i.r1 + i.imm) & 32'hFFFF_FFFE;
      return i.pc + i.imm;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t i, cur, nxt, prev;
      logic [31:0] cur_rdata, prev_rdata;
      bit have_prev;
      int n;

      rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
      drive(nop_instr(), 1'b0);
      #3;
      chk("rst_stall", stall, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wren", wrEn_Mem, 0);
      chk("rst_data", Data_mem_Mem, 0);
      chk("rst_jump", jump_flag, 0);
      chk("rst_exc", {misalign_exc, bus_err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // lb with three wait cycles
      i = nop_instr(); i.alu = 32'h103; i.rd_op = 1; i.size = 0; i.rd = 5; i.wen = 1;
      drive(i, 1'b1); @(posedge clk); #1; drive(nop_instr(), 1'b0);
      dmem_rdata = 32'h80FF_0000;
      repeat (3) begin
         chk("lb_stall", stall, 1);
         @(posedge clk); #1;
      end
      chk("lb_addr", dmem_addr, 32'h100);
      dmem_ack = 1'b1; #1;
      chk("lb_stall_ack", stall, 0);
      @(posedge clk); #1; dmem_ack = 1'b0;
      chk("lb_data", Data_mem_Mem, 32'hFFFF_FF80);
      chk("lb_wren", wrEn_Mem, 1);
      chk("lb_rd", Rd_Mem, 5);

      // sh with zero-wait ack
      i = nop_instr(); i.alu = 32'h202; i.wr_op = 1; i.size = 1; i.r2 = 32'h1234_ABCD;
      drive(i, 1'b1); @(posedge clk); #1; drive(nop_instr(), 1'b0);
      dmem_ack = 1'b1; #1;
      chk("sh_req", dmem_req, 1);
      chk("sh_we", dmem_we, 1);
      chk("sh_stall", stall, 0);
      chk("sh_be", dmem_be, 4'b1100);
      chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
      chk("sh_addr", dmem_addr, 32'h200);
      @(posedge clk); #1; dmem_ack = 1'b0;
      chk("sh_wren", wrEn_Mem, 0);
      chk("sh_wb_valid", wb_valid, 1);

      // misaligned lw
      i = nop_instr(); i.alu = 32'h106; i.rd_op = 1; i.size = 2; i.rd = 3; i.wen = 1;
      drive(i, 1'b1); @(posedge clk); #1; drive(nop_instr(), 1'b0);
      chk("mis_req", dmem_req, 0);
      chk("mis_stall", stall, 0);
      @(posedge clk); #1;
      chk("mis_exc", misalign_exc, 1);
      chk("mis_wren", wrEn_Mem, 0);
      @(posedge clk); #1;
      chk("mis_exc_pulse", misalign_exc, 0);

      // jalr
      i = nop_instr(); i.pc = 32'h2000; i.r1 = 32'h1001; i.imm = 4; i.alu = 32'h2004;
      i.jk = 2'd3; i.rd = 1; i.wen = 1;
      drive(i, 1'b1); @(posedge clk); #1; drive(nop_instr(), 1'b0);
      chk("jalr_flag", jump_flag, 1);
      chk("jalr_target", jump_target_PC, 32'h1004);
      @(posedge clk); #1;
      chk("jalr_data", Data_mem_Mem, 32'h2004);
      chk("jalr_wren", wrEn_Mem, 1);

      // ack timeout
      i = nop_instr(); i.alu = 32'h300; i.rd_op = 1; i.size = 2; i.rd = 9; i.wen = 1;
      drive(i, 1'b1); @(posedge clk); #1; drive(nop_instr(), 1'b0);
      n = 0;
      while (stall && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      chk("tmo_stall_cycles", n, TMO);
      chk("tmo_bus_err", bus_err, 1);
      chk("tmo_req_drain", dmem_req, 0);
      chk("tmo_wren", wrEn_Mem, 0);
      chk("tmo_wb_valid", wb_valid, 1);
      i = nop_instr(); i.alu = 32'hCAFE; i.rd = 7; i.wen = 1;
      drive(i, 1'b1); @(posedge clk); #1; drive(nop_instr(), 1'b0);
      chk("tmo_bus_err_pulse", bus_err, 0);
      @(posedge clk); #1;
      chk("tmo_next_data", Data_mem_Mem, 32'hCAFE);
      chk("tmo_next_wren", wrEn_Mem, 1);

      // reset in the middle of a wait
      i = nop_instr(); i.alu = 32'h400; i.rd_op = 1; i.size = 2; i.rd = 4; i.wen = 1;
      drive(i, 1'b1); @(posedge clk); #1; drive(nop_instr(), 1'b0);
      @(posedge clk); #1;
      chk("rw_stall_before", stall, 1);
      #2 rst = 1'b1; #1;
      chk("rw_req", dmem_req, 0);
      chk("rw_stall", stall, 0);
      @(posedge clk); #1; rst = 1'b0;
      dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
      @(posedge clk); #1; dmem_ack = 1'b0;
      chk("rw_late_ack_valid", wb_valid, 0);
      chk("rw_late_ack_wren", wrEn_Mem, 0);

      // random back-to-back stream with zero-wait acks
      have_prev = 0;
      prev = nop_instr(); prev_rdata = '0;
      cur = rand_instr();
      drive(cur, 1'b1); @(posedge clk); #1;
      for (int k = 0; k < 80; k++) begin
         if (have_prev) begin
            chk("rnd_wb_valid", wb_valid, 1);
            chk("rnd_rd", Rd_Mem, prev.rd);
            chk("rnd_wren", wrEn_Mem, m_wren(prev));
            chk("rnd_misalign", misalign_exc, m_memop(prev) && !m_aligned(prev));
            if (!m_memop(prev)) chk("rnd_alu_data", Data_mem_Mem, prev.alu);
            else if (prev.rd_op && m_aligned(prev))
               chk("rnd_load_data", Data_mem_Mem, m_load(prev, prev_rdata));
         end
         cur_rdata = $urandom;
         dmem_rdata = cur_rdata;
         dmem_ack = m_req(cur);
         nxt = rand_instr();
         drive(nxt, 1'b1);
         #1;
         chk("rnd_req", dmem_req, m_req(cur));
         chk("rnd_stall", stall, 0);
         chk("rnd_jump", jump_flag, m_taken(cur));
         if (m_taken(cur)) chk("rnd_target", jump_target_PC, m_target(cur));
         if (m_req(cur)) begin
            chk("rnd_addr", dmem_addr, cur.alu & 32'hFFFF_FFFC);
            chk("rnd_we", dmem_we, cur.wr_op);
            chk("rnd_be", dmem_be, m_be(cur));
            if (cur.wr_op) chk("rnd_wdata", dmem_wdata, m_wdata(cur));
         end
         prev = cur; prev_rdata = cur_rdata; cur = nxt; have_prev = 1;
         @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
      drive(nop_instr(), 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
